mem_ctrl: RTL and testbench

Memory controller serving the byte-wide unified RAM/IO bus: the responder end of the load/store buffer's memory request interface, plus a lower-priority instruction-fetch port. It converts one LSB word, half or byte request, or one 32-bit fetch, into a sequence of single-byte RAM accesses. It then returns one result pulse. It sits between the LSB / instruction fetch unit and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl_load_ext.sv | 23 ++
 rtl/mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: funct3 codes, FSM encoding,
// the default IO window base and the request-size decode.
package mem_ctrl_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Byte count from funct3[1:0]; the unused 2'b11 code is treated as a word.
  function automatic logic [2:0] xfer_len(input logic [1:0] size);
    case (size)
      F3_SB[1:0]: xfer_len = 3'd1;
      F3_SH[1:0]: xfer_len = 3'd2;
      F3_SW[1:0]: xfer_len = 3'd4;
      default:    xfer_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load result formatting: picks the low byte/half/word of the assembled
// little-endian bytes and sign- or zero-extends it according to funct3.
module mem_ctrl_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word_in,
  output logic [31:0] result
);

  always_comb begin
    result = word_in;
    case (funct3)
      F3_LB:   result = {{24{word_in[7]}}, word_in[7:0]};
      F3_LH:   result = {{16{word_in[15]}}, word_in[15:0]};
      F3_LW:   result = word_in;
      F3_LBU:  result = {24'd0, word_in[7:0]};
      F3_LHU:  result = {16'd0, word_in[15:0]};
      default: result = word_in;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns one LSB load/store or one 32-bit
// instruction fetch into single-byte RAM accesses and returns one result pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        lsb_req,
  input  logic        lsb_is_store,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic [2:0]  lsb_op,
  output logic        mem_res_avail,
  output logic [31:0] mem_res,
  output logic        mem_stuck,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [2:0]  state_dbg
);

  // Handshake: lsb_req / if_req are levels held by the requester until the
  // cycle after its one-cycle completion pulse; acceptance happens only in IDLE.
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, len_q, op_q;
  logic [31:0] base_q, st_data_q, rd_word_q, asm_word, ext_word;
  logic        flush_q, avail_q, if_done_q, wr_q;
  logic        lsb_blocked, accept_lsb, accept_if, rd_last, wr_last;

  assign mem_stuck     = io_buffer_full;
  assign mem_wr        = wr_q & rdy_in;
  assign mem_res_avail = avail_q & ~rob_clear;
  assign if_done       = if_done_q & ~rob_clear;
  assign state_dbg     = state_q;

  always_comb begin
    lsb_blocked = lsb_is_store && io_buffer_full && (lsb_addr >= IO_BASE);
    accept_lsb  = (state_q == ST_IDLE) && lsb_req && !lsb_blocked;
    accept_if   = (state_q == ST_IDLE) && !accept_lsb && if_req;
    // Reads land two edges after their address, so the last one is at len+1.
    rd_last     = (cnt_q == len_q + 3'd1);
    wr_last     = (cnt_q == len_q);
    state_d     = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_lsb)     state_d = lsb_is_store ? ST_STORE : ST_LOAD;
        else if (accept_if) state_d = ST_FETCH;
      end
      ST_LOAD, ST_FETCH: begin
        if (rob_clear)    state_d = ST_IDLE;
        else if (rd_last) state_d = ST_DONE;
      end
      ST_STORE: if (wr_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read data for the byte issued two edges ago, merged over earlier bytes.
  always_comb begin
    asm_word = rd_word_q;
    asm_word[{cnt_q[1:0] - 2'd2, 3'b000} +: 8] = mem_din;
  end

  mem_ctrl_load_ext u_load_ext (
    .funct3  (op_q),
    .word_in (asm_word),
    .result  (ext_word)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      op_q      <= '0;
      base_q    <= '0;
      st_data_q <= '0;
      rd_word_q <= '0;
      flush_q   <= 1'b0;
      avail_q   <= 1'b0;
      if_done_q <= 1'b0;
      wr_q      <= 1'b0;
      mem_res   <= '0;
      if_data   <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      avail_q   <= 1'b0;
      if_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q     <= 3'd1;
          rd_word_q <= '0;
          flush_q   <= 1'b0;
          if (accept_lsb) begin
            base_q    <= lsb_addr;
            op_q      <= lsb_op;
            len_q     <= xfer_len(lsb_op[1:0]);
            st_data_q <= lsb_data;
            mem_a     <= lsb_addr;
            mem_dout  <= lsb_data[7:0];
            wr_q      <= lsb_is_store;
          end else if (accept_if) begin
            base_q <= if_addr;
            op_q   <= F3_LW;
            len_q  <= 3'd4;
            mem_a  <= if_addr;
            wr_q   <= 1'b0;
          end
        end
        ST_LOAD, ST_FETCH: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < len_q)   mem_a <= base_q + {29'd0, cnt_q};
          if (cnt_q >= 3'd2)   rd_word_q <= asm_word;
          if (rd_last && !rob_clear) begin
            if (state_q == ST_LOAD) begin
              avail_q <= 1'b1;
              mem_res <= ext_word;
            end else begin
              if_done_q <= 1'b1;
              if_data   <= asm_word;
            end
          end
        end
        ST_STORE: begin
          // A committed store always finishes; a flush only hides its pulse.
          flush_q <= flush_q | rob_clear;
          if (!wr_last) begin
            cnt_q    <= cnt_q + 3'd1;
            mem_a    <= base_q + {29'd0, cnt_q};
            mem_dout <= st_data_q[{cnt_q[1:0], 3'b000} +: 8];
          end else begin
            wr_q    <= 1'b0;
            mem_res <= '0;
            avail_q <= !(flush_q || rob_clear);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, transaction-level
// reference model with per-cycle expectation maps, directed plus random traffic.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, lsb_req, lsb_is_store;
  logic [31:0] lsb_addr, lsb_data, if_addr;
  logic [2:0]  lsb_op;
  logic        if_req, io_buffer_full;
  logic [7:0]  mem_din;
  logic        mem_res_avail, mem_stuck, if_done, mem_wr;
  logic [31:0] mem_res, if_data, mem_a;
  logic [7:0]  mem_dout;
  logic [2:0]  state_dbg;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .lsb_req(lsb_req), .lsb_is_store(lsb_is_store), .lsb_addr(lsb_addr),
    .lsb_data(lsb_data), .lsb_op(lsb_op), .mem_res_avail(mem_res_avail),
    .mem_res(mem_res), .mem_stuck(mem_stuck), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- RAM model (12-bit window, 2-edge read latency) ----------------
  bit [7:0] ram_mem [0:4095];
  bit       ram_v   [0:4095];
  bit [7:0] mdl_mem [0:4095];
  bit       mdl_v   [0:4095];

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    case (a)
      12'h100: init_byte = 8'h78;
      12'h101: init_byte = 8'h56;
      12'h102: init_byte = 8'h34;
      12'h103: init_byte = 8'h12;
      12'h040: init_byte = 8'h80;
      default: init_byte = (a[7:0] ^ {a[11:8], a[11:8]}) * 8'd29 + 8'd7;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    ram_rd = ram_v[a[11:0]] ? ram_mem[a[11:0]] : init_byte(a[11:0]);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    mdl_rd = mdl_v[a[11:0]] ? mdl_mem[a[11:0]] : init_byte(a[11:0]);
  endfunction

  always @(posedge clk_in) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram_mem[mem_a[11:0]] <= mem_dout;
      ram_v[mem_a[11:0]]   <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  bit          pulse_at [int];
  bit          fetch_at [int];
  bit          wr_at    [int];
  logic [31:0] exp_q[$];
  logic [31:0] if_q[$];
  int          idle_from = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_res = '0;
  logic [31:0] last_if = '0;

  function automatic int len_of(input logic [2:0] op);
    len_of = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] b0, b1, b2, b3, h;
    b0 = {24'd0, mdl_rd(a)};
    b1 = {24'd0, mdl_rd(a + 32'd1)};
    b2 = {24'd0, mdl_rd(a + 32'd2)};
    b3 = {24'd0, mdl_rd(a + 32'd3)};
    h  = b0 + 32'd256 * b1;
    case (op)
      3'b000:  model_load = b0 - ((b0 >= 32'd128) ? 32'd256 : 32'd0);
      3'b001:  model_load = h - ((h >= 32'd32768) ? 32'd65536 : 32'd0);
      3'b100:  model_load = b0;
      3'b101:  model_load = h;
      default: model_load = h + 32'd65536 * b2 + 32'd16777216 * b3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  initial forever begin
    @(negedge clk_in);
    if (chk_en) begin
      check("mem_res_avail", mem_res_avail, pulse_at.exists(cyc));
      if (pulse_at.exists(cyc)) begin
        if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
        else check("mem_res", mem_res, exp_q.pop_front());
      end
      if (mem_res_avail) last_res = mem_res;
      check("if_done", if_done, fetch_at.exists(cyc));
      if (fetch_at.exists(cyc)) begin
        if (if_q.size() == 0) check("if_q_empty", 1, 0);
        else check("if_data", if_data, if_q.pop_front());
      end
      if (if_done) last_if = if_data;
      check("mem_wr", mem_wr, wr_at.exists(cyc));
      check("mem_stuck", mem_stuck, io_buffer_full);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  function automatic int accept_edge();
    accept_edge = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
  endfunction

  // flush_k < 0: no flush; otherwise rob_clear is sampled at edge T+flush_k.
  task automatic run_lsb(input bit st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int flush_k, input int stall);
    int t, n, p;
    n = len_of(op);
    if (stall > 0) io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_is_store = st; lsb_op = op; lsb_addr = addr; lsb_data = data;
    if (stall > 0) begin
      repeat (stall) step();
      io_buffer_full = 1'b0;
    end
    t = accept_edge();
    if (st) begin
      for (int k = 0; k < n; k++) begin
        wr_at[t + k] = 1'b1;
        mdl_mem[(addr + 32'(k)) & 32'hFFF] = data[8*k +: 8];
        mdl_v[(addr + 32'(k)) & 32'hFFF]   = 1'b1;
      end
      p = t + n;
      idle_from = t + n + 2;
      if (flush_k < 0) begin
        pulse_at[p] = 1'b1;
        exp_q.push_back(32'd0);
      end
    end else begin
      p = t + n + 1;
      if (flush_k < 0) begin
        pulse_at[p] = 1'b1;
        exp_q.push_back(model_load(op, addr));
        idle_from = t + n + 3;
      end else begin
        idle_from = t + flush_k + 1;
      end
    end
    if (flush_k >= 0) begin
      wait_until(t + flush_k - 1);
      rob_clear = 1'b1;
      lsb_req = 1'b0;
      step();
      rob_clear = 1'b0;
      if (!st) check("state_after_flush", {29'd0, state_dbg}, {29'd0, ST_IDLE});
      wait_until(idle_from - 1);
    end else begin
      wait_until(p + 1);
      lsb_req = 1'b0;
    end
    if (st) begin
      for (int k = 0; k < n; k++)
        check("ram_byte", {24'd0, ram_rd(addr + 32'(k))}, {24'd0, mdl_rd(addr + 32'(k))});
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr);
    int t;
    if_req = 1'b1;
    if_addr = addr;
    t = accept_edge();
    fetch_at[t + 5] = 1'b1;
    if_q.push_back(model_load(F3_LW, addr));
    idle_from = t + 7;
    wait_until(t + 6);
    if_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t1, t2, t;
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; lsb_req = 1'b0; lsb_is_store = 1'b0;
    lsb_addr = '0; lsb_data = '0; lsb_op = '0; if_req = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0;
    #1 rst_in = 1'b1;
    #2;
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", {24'd0, mem_dout}, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_res_avail", mem_res_avail, 0);
    check("rst_mem_res", mem_res, 0);
    check("rst_if_done", if_done, 0);
    check("rst_if_data", if_data, 0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    idle_from = cyc + 1;
    chk_en = 1'b1;

    // Directed cases with literal results.
    run_lsb(1'b0, F3_LW, 32'h100, 32'h0, -1, 0);
    check("lw_literal", last_res, 32'h1234_5678);
    run_lsb(1'b0, F3_LBU, 32'h40, 32'h0, -1, 0);
    check("lbu_literal", last_res, 32'h0000_0080);
    run_lsb(1'b1, F3_SH, 32'h201, 32'h0000_ABCD, -1, 0);
    check("sh_res_literal", last_res, 32'h0);
    check("sh_byte0_literal", {24'd0, ram_rd(32'h201)}, 32'hCD);
    check("sh_byte1_literal", {24'd0, ram_rd(32'h202)}, 32'hAB);

    // Both requests at once: LB goes first, fetch follows after DONE.
    lsb_req = 1'b1; lsb_is_store = 1'b0; lsb_op = F3_LB; lsb_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h100;
    t1 = accept_edge();
    pulse_at[t1 + 2] = 1'b1;
    exp_q.push_back(model_load(F3_LB, 32'h40));
    t2 = t1 + 4;
    fetch_at[t2 + 5] = 1'b1;
    if_q.push_back(model_load(F3_LW, 32'h100));
    wait_until(t1 + 3);
    lsb_req = 1'b0;
    wait_until(t2 + 6);
    if_req = 1'b0;
    idle_from = t2 + 7;
    check("lb_literal", last_res, 32'hFFFF_FF80);
    check("fetch_literal", last_if, 32'h1234_5678);

    // Flushes: LW aborted in its third cycle, SW still writes all bytes.
    run_lsb(1'b0, F3_LW, 32'h100, 32'h0, 3, 0);
    run_lsb(1'b1, F3_SW, 32'h280, 32'hDEAD_BEEF, 2, 0);
    check("sw_flush_literal", {24'd0, ram_rd(32'h283)}, 32'hDE);

    // IO stall, then a wrap-around word load.
    run_lsb(1'b1, F3_SB, 32'h0003_0000, 32'h0000_005A, -1, 5);
    check("io_sb_literal", {24'd0, ram_rd(32'h0003_0000)}, 32'h5A);
    run_lsb(1'b0, F3_LW, 32'hFFFF_FFFE, 32'h0, -1, 0);
    run_fetch(32'hFFFF_FFFD);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int sel, fk;
      logic [2:0] op;
      logic [31:0] a;
      repeat ($urandom_range(0, 2)) step();
      sel = $urandom_range(0, 8);
      a = $urandom_range(0, 32'hFFF);
      case (sel)
        0: op = F3_LB;  1: op = F3_LH;  2: op = F3_LW;
        3: op = F3_LBU; 4: op = F3_LHU; 5: op = F3_SB;
        6: op = F3_SH;  default: op = F3_SW;
      endcase
      fk = -1;
      if ($urandom_range(0, 4) == 0)
        fk = (sel >= 5) ? $urandom_range(1, len_of(op)) : $urandom_range(1, len_of(op) + 1);
      if (sel == 8) run_fetch(a);
      else run_lsb(sel >= 5, op, a, $urandom(), fk, 0);
    end

    // Reset in the middle of a SW: only the first byte may land.
    lsb_req = 1'b1; lsb_is_store = 1'b1; lsb_op = F3_SW; lsb_addr = 32'h380;
    lsb_data = 32'h4433_2211;
    t = accept_edge();
    wr_at[t] = 1'b1;
    mdl_mem[12'h380] = 8'h11;
    mdl_v[12'h380]   = 1'b1;
    wait_until(t + 1);
    #2 rst_in = 1'b1;
    #1;
    lsb_req = 1'b0;
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_mem_a", mem_a, 0);
    check("midrst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    step();
    rst_in = 1'b0;
    idle_from = cyc + 1;
    for (int k = 0; k < 4; k++)
      check("midrst_ram", {24'd0, ram_rd(32'h380 + 32'(k))}, {24'd0, mdl_rd(32'h380 + 32'(k))});
    run_lsb(1'b0, F3_LW, 32'h380, 32'h0, -1, 0);

    repeat (3) step();
    if (exp_q.size() != 0 || if_q.size() != 0) check("leftover_expectations", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
